lpf_multi_enc: RTL and testbench

Multi-channel, parametrised glitch filter for quadrature/index encoder inputs (A, B, Z and similar). Each channel synchronises its raw input, rejects any level excursion not held for more than a programmable number of clock cycles, and publishes the filtered level plus single-cycle edge strobes. Rise and fall thresholds are separate, and a per-channel saturating counter records rejected glitches. The block sits between the encoder pins and the position decoder and replaces the single-channel encoder low-pass filter.

---
 rtl/lpf_multi_enc.sv | 121 ++++++++++++
 tb/tb_lpf_multi_enc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lpf_multi_enc.sv
// lpf_multi_enc: per-channel synchroniser and run-length glitch filter for encoder inputs.
// Filtered levels, edge strobes and saturating glitch counts are all registered outputs.
module lpf_multi_enc #(
  parameter int CH   = 3,
  parameter int SYNC = 2,
  parameter int CW   = 14,
  parameter int GW   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    signal,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    th_rise,
  input  logic [CW-1:0]    th_fall,
  input  logic             glitch_clr,
  output logic [CH-1:0]    sig_filter,
  output logic [CH-1:0]    rise_p,
  output logic [CH-1:0]    fall_p,
  output logic [CH-1:0]    glitch_p,
  output logic [CH*GW-1:0] glitch_cnt
);

  localparam logic [1:0]    MODE_BYPASS = 2'd0;
  localparam logic [1:0]    MODE_SYM    = 2'd1;
  localparam logic [1:0]    MODE_ASYM   = 2'd2;
  localparam logic [1:0]    MODE_FREEZE = 2'd3;
  localparam logic [CW:0]   RUN_MAX     = '1;
  localparam logic [GW-1:0] CNT_MAX     = '1;

  // Mode decode shared by every channel.
  logic filter_active;
  logic count_enable;

  always_comb begin
    filter_active = (mode != MODE_FREEZE);
    count_enable  = (mode == MODE_SYM) || (mode == MODE_ASYM);
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi = gi + 1) begin : g_ch
      logic [SYNC-1:0] sync_reg;
      logic            v;
      logic            differ;
      logic [CW-1:0]   thr;
      logic            accept;
      logic            reject;
      logic            filt_reg;
      logic            filt_next;
      logic [CW:0]     run_reg;
      logic [CW:0]     run_next;
      logic [GW-1:0]   cnt_reg;
      logic [GW-1:0]   cnt_next;
      logic            rise_reg;
      logic            fall_reg;
      logic            glitch_reg;

      // Threshold for the pending direction: v is the level trying to win.
      always_comb begin
        v      = sync_reg[SYNC-1];
        differ = (v != filt_reg);
        case (mode)
          MODE_BYPASS: thr = '0;
          MODE_ASYM:   thr = v ? th_rise : th_fall;
          default:     thr = th_rise;
        endcase
      end

      // run_reg holds the number of samples already seen at the new level, so the
      // current sample is number run_reg+1 and acceptance needs run_reg >= T.
      always_comb begin
        accept    = filter_active && differ && (run_reg >= {1'b0, thr});
        reject    = count_enable && !differ && (run_reg != '0);
        filt_next = accept ? v : filt_reg;

        if (!differ || accept) begin
          run_next = '0;
        end else if (run_reg == RUN_MAX) begin
          run_next = run_reg;
        end else begin
          run_next = run_reg + 1'b1;
        end

        if (glitch_clr) begin
          cnt_next = '0;
        end else if (reject && (cnt_reg != CNT_MAX)) begin
          cnt_next = cnt_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_reg   <= '0;
          filt_reg   <= 1'b0;
          run_reg    <= '0;
          cnt_reg    <= '0;
          rise_reg   <= 1'b0;
          fall_reg   <= 1'b0;
          glitch_reg <= 1'b0;
        end else begin
          sync_reg   <= {sync_reg[SYNC-2:0], signal[gi]};
          filt_reg   <= filt_next;
          run_reg    <= run_next;
          cnt_reg    <= cnt_next;
          rise_reg   <= accept && v;
          fall_reg   <= accept && !v;
          glitch_reg <= reject;
        end
      end

      assign sig_filter[gi]           = filt_reg;
      assign rise_p[gi]               = rise_reg;
      assign fall_p[gi]               = fall_reg;
      assign glitch_p[gi]             = glitch_reg;
      assign glitch_cnt[gi*GW +: GW]  = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_lpf_multi_enc.sv
// Directed bench for lpf_multi_enc: hand-computed levels, strobes and counts per step.
module tb_lpf_multi_enc;
  localparam int CH   = 3;
  localparam int SYNC = 2;
  localparam int CW   = 14;
  localparam int GW   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [CH-1:0]    signal;
  logic [1:0]       mode;
  logic [CW-1:0]    th_rise;
  logic [CW-1:0]    th_fall;
  logic             glitch_clr;
  logic [CH-1:0]    sig_filter;
  logic [CH-1:0]    rise_p;
  logic [CH-1:0]    fall_p;
  logic [CH-1:0]    glitch_p;
  logic [CH*GW-1:0] glitch_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int obs_rise[CH];
  int obs_fall[CH];
  int obs_gl[CH];

  always #5 clk = ~clk;

  lpf_multi_enc #(.CH(CH), .SYNC(SYNC), .CW(CW), .GW(GW)) dut (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode),
    .th_rise(th_rise), .th_fall(th_fall), .glitch_clr(glitch_clr),
    .sig_filter(sig_filter), .rise_p(rise_p), .fall_p(fall_p),
    .glitch_p(glitch_p), .glitch_cnt(glitch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
    $display("cmp %-22s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic clr_obs();
    for (int c = 0; c < CH; c++) begin
      obs_rise[c] = 0;
      obs_fall[c] = 0;
      obs_gl[c]   = 0;
    end
  endtask

  // Advance n clocks; outputs are sampled on the falling edge and strobes tallied.
  task automatic hold(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        obs_rise[c] += (rise_p[c] === 1'b1) ? 1 : 0;
        obs_fall[c] += (fall_p[c] === 1'b1) ? 1 : 0;
        obs_gl[c]   += (glitch_p[c] === 1'b1) ? 1 : 0;
      end
    end
  endtask

  function automatic int strobe_total();
    int s = 0;
    for (int c = 0; c < CH; c++) s += obs_rise[c] + obs_fall[c] + obs_gl[c];
    return s;
  endfunction

  initial begin
    reset = 1'b1; signal = '0; mode = 2'd1; th_rise = 14'd4; th_fall = 14'd4;
    glitch_clr = 1'b0;
    clr_obs();
    hold(3);
    check("reset_filter", 32'(sig_filter), 32'h0);
    check("reset_strobes", 32'({rise_p, fall_p, glitch_p}), 32'h0);
    check("reset_cnt", 32'(glitch_cnt), 32'h0);
    reset = 1'b0;
    hold(4);

    // Symmetric T=4: 4-cycle pulse rejected
    clr_obs();
    signal[0] = 1'b1; hold(4);
    signal[0] = 1'b0; hold(10);
    check("sym4_filter", 32'(sig_filter[0]), 32'h0);
    check("sym4_glitch_p", 32'(obs_gl[0]), 32'd1);
    check("sym4_rise_p", 32'(obs_rise[0]), 32'd0);
    check("sym4_cnt", 32'(glitch_cnt[3:0]), 32'd1);

    // 5-cycle pulse accepted 7 edges after capture, then falls back
    clr_obs();
    signal[0] = 1'b1; hold(5);
    signal[0] = 1'b0; hold(1);
    check("sym5_edge6", 32'(sig_filter[0]), 32'h0);
    hold(1);
    check("sym5_edge7", 32'(sig_filter[0]), 32'h1);
    check("sym5_rise_p", 32'(rise_p[0]), 32'h1);
    hold(1);
    check("sym5_rise_once", 32'(rise_p[0]), 32'h0);
    hold(10);
    check("sym5_fell", 32'(sig_filter[0]), 32'h0);
    check("sym5_fall_cnt", 32'(obs_fall[0]), 32'd1);
    check("sym5_no_glitch", 32'(obs_gl[0]), 32'd0);

    // Asymmetric: rise T=2, fall T=10
    clr_obs();
    mode = 2'd2; th_rise = 14'd2; th_fall = 14'd10;
    signal[0] = 1'b1; hold(3);
    signal[0] = 1'b0; hold(10);
    signal[0] = 1'b1; hold(5);
    check("asym_rise3", 32'(sig_filter[0]), 32'h1);
    check("asym_rise_cnt", 32'(obs_rise[0]), 32'd1);
    check("asym_gap10_glitch", 32'(obs_gl[0]), 32'd1);
    signal[0] = 1'b0; hold(12);
    check("asym_fall_edge12", 32'(sig_filter[0]), 32'h1);
    hold(1);
    check("asym_fall_edge13", 32'(sig_filter[0]), 32'h0);
    check("asym_fall_p", 32'(fall_p[0]), 32'h1);
    check("asym_cnt", 32'(glitch_cnt[3:0]), 32'd2);

    // Bypass: SYNC+1 latency, no glitches
    clr_obs();
    mode = 2'd0;
    signal[0] = 1'b1; hold(2);
    check("byp_edge2", 32'(sig_filter[0]), 32'h0);
    hold(1);
    check("byp_edge3_rise", 32'(sig_filter[0]), 32'h1);
    signal[0] = 1'b0; hold(3);
    check("byp_fall", 32'(sig_filter[0]), 32'h0);
    signal[0] = 1'b1; hold(3);
    check("byp_rise2", 32'(sig_filter[0]), 32'h1);
    check("byp_strobes", 32'({obs_rise[0][7:0], obs_fall[0][7:0], obs_gl[0][7:0]}), 32'h020100);

    // Freeze while high, drive low 50 cycles, then leave freeze
    clr_obs();
    mode = 2'd3; signal[0] = 1'b0; hold(50);
    check("frz_hold", 32'(sig_filter[0]), 32'h1);
    check("frz_no_strobes", 32'(strobe_total()), 32'd0);
    mode = 2'd1; th_rise = 14'd4; hold(1);
    check("frz_exit_fall", 32'(sig_filter[0]), 32'h0);
    check("frz_exit_fall_p", 32'(fall_p[0]), 32'h1);
    check("frz_cnt_kept", 32'(glitch_cnt[3:0]), 32'd2);

    // Saturation on channel 1: 20 glitches -> 15
    clr_obs();
    for (int i = 0; i < 20; i++) begin
      signal[1] = 1'b1; hold(2);
      signal[1] = 1'b0; hold(6);
    end
    check("sat_glitch_p", 32'(obs_gl[1]), 32'd20);
    check("sat_cnt", 32'(glitch_cnt[7:4]), 32'd15);
    check("sat_filter", 32'(sig_filter[1]), 32'h0);

    // glitch_clr coincident with a glitch increment
    signal[1] = 1'b1; hold(2);
    signal[1] = 1'b0; hold(2);
    glitch_clr = 1'b1; hold(1);
    glitch_clr = 1'b0;
    check("clr_glitch_p", 32'(glitch_p[1]), 32'h1);
    check("clr_cnt_all", 32'(glitch_cnt), 32'h0);
    hold(3);
    signal[1] = 1'b1; hold(2);
    signal[1] = 1'b0; hold(6);
    check("clr_recount", 32'(glitch_cnt[7:4]), 32'd1);

    // Reset during a pending excursion on ch2 with ch0 filtered high
    signal[0] = 1'b1; hold(8);
    check("rst_pre_ch0", 32'(sig_filter[0]), 32'h1);
    signal[2] = 1'b1; hold(5);
    reset = 1'b1; hold(1);
    reset = 1'b0;
    check("rst_filter", 32'(sig_filter), 32'h0);
    check("rst_strobes", 32'({rise_p, fall_p, glitch_p}), 32'h0);
    check("rst_cnt", 32'(glitch_cnt), 32'h0);
    clr_obs();
    hold(6);
    check("rst_edge6", 32'(sig_filter), 32'h0);
    hold(1);
    check("rst_edge7", 32'(sig_filter), 32'h5);
    check("rst_rise_p", 32'(rise_p), 32'h5);
    check("rst_no_glitch", 32'(obs_gl[0] + obs_gl[1] + obs_gl[2]), 32'd0);

    // Live threshold change 100 -> 2 after 10 samples
    signal = '0; hold(10);
    check("thr_idle", 32'(sig_filter), 32'h0);
    th_rise = 14'd100;
    signal[1] = 1'b1; hold(12);
    check("thr_pending", 32'(sig_filter[1]), 32'h0);
    th_rise = 14'd2; hold(1);
    check("thr_accept", 32'(sig_filter[1]), 32'h1);
    check("thr_rise_p", 32'(rise_p[1]), 32'h1);

    // All channels toggle together
    th_rise = 14'd4;
    signal = '0; hold(10);
    signal = 3'b111; hold(6);
    check("multi_edge6", 32'(sig_filter), 32'h0);
    hold(1);
    check("multi_rise", 32'(sig_filter), 32'h7);
    check("multi_rise_p", 32'(rise_p), 32'h7);
    signal = '0; hold(7);
    check("multi_fall_p", 32'(fall_p), 32'h7);
    check("multi_fall", 32'(sig_filter), 32'h0);
    signal = 3'b111; hold(2);
    signal = '0; hold(2);
    hold(1);
    check("multi_glitch_p", 32'(glitch_p), 32'h7);
    check("multi_cnt", 32'(glitch_cnt), 32'h111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
